instr_encoder: RTL

- RV32I instruction encoder and the inverse of the ID-stage decoder. It packs opcode, funct, register and immediate fields into 32-bit instruction words.
- Used by the boot/self-test program generator and the trace/patch unit to write instruction memory.
- Input side uses a valid/ready handshake. Output side is a DEPTH-entry FIFO with its own valid/ready handshake.
- Invariant: feeding an output word to the decoder returns the original rs1/rs2/rd/imm fields.

---
 rtl/instr_encoder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   RV32I instruction encoder: packs opcode/funct/register/immediate fields
//   into a 32-bit instruction word and queues {word, err} in a small output
//   FIFO. Inverse of the ID-stage decoder.
//
//   Optional build macro: ENC_RANGE_CHECK_EN
//     When defined, err is also raised for immediates that do not fit their
//     format (word is still encoded with truncation). When undefined, err
//     flags only unsupported opcodes and no range logic exists.
//
// Parameters
//   DEPTH  output FIFO entries (power of two, >= 2)
//   CNT_W  width of the accepted field-set counter
//
// Ports
//   clk       core clock
//   rstn_i    asynchronous active-low reset
//   valid_i   field set valid            ready_o  encoder can accept
//   opcode_i, funct3_i, funct7_i, rs1_i, rs2_i, rd_i, imm_i  field set
//   valid_o   FIFO head valid            ready_i  consumer accepts head
//   instr_o   head word (0 when empty)   err_o    head error flag
//   cnt_o     number of accepted field sets (wraps)
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [4:0]       rd_i,
    input  logic [31:0]      imm_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      instr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_IMM_ALU = 7'b0010011;
    localparam logic [6:0] OP_REG_ALU = 7'b0110011;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // Returns {err, word}; err here only marks an unsupported opcode.
    function automatic logic [32:0] encode(
        input logic [6:0]  op,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [31:0] imm
    );
        logic [32:0] res;
        case (op)
            OP_LUI, OP_AUIPC:
                res = {1'b0, imm[31:12], rd, op};
            OP_IMM_ALU, OP_LOAD, OP_JALR:
                res = {1'b0, imm[11:0], rs1, f3, rd, op};
            OP_REG_ALU:
                res = {1'b0, f7, rs2, rs1, f3, rd, op};
            OP_STORE:
                res = {1'b0, imm[11:5], rs2, rs1, f3, imm[4:0], op};
            OP_BRANCH:
                res = {1'b0, imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            OP_JAL:
                res = {1'b0, imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default:
                res = {1'b1, NOP_WORD};
        endcase
        return res;
    endfunction

`ifdef ENC_RANGE_CHECK_EN
    // High when the immediate does not fit the format of the opcode.
    function automatic logic range_err(input logic [6:0] op, input logic [31:0] imm);
        logic bad;
        case (op)
            OP_IMM_ALU, OP_LOAD, OP_JALR, OP_STORE:
                bad = (imm[31:11] != {21{imm[11]}});
            OP_BRANCH:
                bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            OP_JAL:
                bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            OP_LUI, OP_AUIPC:
                bad = (imm[11:0] != 12'h000);
            default:
                bad = 1'b0;
        endcase
        return bad;
    endfunction
`endif

    logic [32:0]      enc_s;
    logic             rng_err_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;

    logic [32:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   fill_r;
    logic [CNT_W-1:0] cnt_r;

    // Combinational encode of the presented field set.
    always_comb begin
        enc_s = encode(opcode_i, funct3_i, funct7_i, rs1_i, rs2_i, rd_i, imm_i);
    end

    // Immediate range error (tied low unless the range check is built in).
    always_comb begin
`ifdef ENC_RANGE_CHECK_EN
        rng_err_s = range_err(opcode_i, imm_i);
`else
        rng_err_s = 1'b0;
`endif
    end

    assign full_s  = (fill_r == (PTR_W+1)'(DEPTH));
    assign empty_s = (fill_r == {(PTR_W+1){1'b0}});
    // ready_o depends only on the fill level, so a pop in the same cycle
    // never frees a slot for a push while full.
    assign push_s  = valid_i && !full_s;
    assign pop_s   = !empty_s && ready_i;

    // FIFO storage: write {err, word} at the write pointer.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 33'd0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {enc_s[32] | rng_err_s, enc_s[31:0]};
        end
    end

    // Pointers, fill level and accepted-word counter.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= {(PTR_W+1){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                cnt_r    <= cnt_r + CNT_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + (PTR_W+1)'(1);
                2'b01:   fill_r <= fill_r - (PTR_W+1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Head presentation: zeros whenever the FIFO is empty.
    always_comb begin
        if (!empty_s) begin
            {err_o, instr_o} = mem_r[rd_ptr_r];
        end else begin
            {err_o, instr_o} = 33'd0;
        end
    end

    assign valid_o = !empty_s;
    assign ready_o = !full_s;
    assign cnt_o   = cnt_r;

endmodule
